// File: rtl/nfa_query_dispatcher.sv
// Routes an input line stream either into NFA memory writes or into a
// serialised stream of query words, with sticky protocol/overflow flags.
module nfa_query_dispatcher #(
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned QUERY_WIDTH    = 64,
    parameter int unsigned NFA_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_ttype,
    output logic                      nfa_wr_en,
    output logic [NFA_ADDR_WIDTH-1:0] nfa_wr_addr,
    output logic [DATA_WIDTH-1:0]     nfa_wr_data,
    output logic                      nfa_loaded,
    output logic                      m_query_tvalid,
    input  logic                      m_query_tready,
    output logic [QUERY_WIDTH-1:0]    m_query_tdata,
    output logic                      m_query_tlast,
    output logic                      nfa_overflow,
    output logic                      proto_err,
    output logic [31:0]               query_words_out
);

    localparam int unsigned LANES  = DATA_WIDTH / QUERY_WIDTH;
    localparam int unsigned SLOT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [SLOT_W-1:0]         LAST_SLOT = SLOT_W'(LANES - 1);
    localparam logic [NFA_ADDR_WIDTH-1:0] MAX_ADDR  = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_NFA = 2'd1,
        QUERY    = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [NFA_ADDR_WIDTH-1:0]   line_cnt;
    logic [DATA_WIDTH-1:0]       buf_line;
    logic                        buf_last;
    logic [SLOT_W-1:0]           slot;
    logic [SLOT_W-1:0]           slot_nxt;
    logic [QUERY_WIDTH-1:0]      lane_nxt;

    logic in_hs;
    logic q_hs;
    logic last_slot_hs;
    logic nfa_accept;
    logic q_accept;
    logic proto_hit;

    assign q_hs         = m_query_tvalid && m_query_tready;
    assign last_slot_hs = q_hs && (slot == LAST_SLOT);
    assign in_hs        = s_axis_tvalid && s_axis_tready;
    assign nfa_accept   = in_hs && !s_axis_ttype && (state == IDLE || state == LOAD_NFA);
    assign q_accept     = in_hs &&  s_axis_ttype && (state == IDLE || state == QUERY);
    assign proto_hit    = in_hs && ((state == LOAD_NFA && s_axis_ttype) ||
                                    (state == QUERY    && !s_axis_ttype));
    assign slot_nxt     = slot + SLOT_W'(1);
    assign lane_nxt     = buf_line[QUERY_WIDTH * 32'(slot_nxt) +: QUERY_WIDTH];

    // NFA path never stalls; query path accepts into an empty or draining buffer
    always_comb begin
        s_axis_tready = 1'b1;
        if (state == QUERY) begin
            s_axis_tready = !m_query_tvalid || last_slot_hs;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (nfa_accept && !s_axis_tlast) begin
                    state_nxt = LOAD_NFA;
                end else if (q_accept) begin
                    state_nxt = QUERY;
                end
            end
            LOAD_NFA: begin
                if (nfa_accept && s_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            QUERY: begin
                // a line accepted during the final handoff keeps the section open
                if (last_slot_hs && buf_last && !q_accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NFA write port and line counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nfa_wr_en    <= 1'b0;
            nfa_wr_addr  <= '0;
            nfa_wr_data  <= '0;
            nfa_loaded   <= 1'b0;
            line_cnt     <= '0;
            nfa_overflow <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            nfa_wr_en  <= nfa_accept;
            nfa_loaded <= nfa_accept && s_axis_tlast;
            if (nfa_accept) begin
                nfa_wr_addr <= line_cnt;
                nfa_wr_data <= s_axis_tdata;
                if (s_axis_tlast) begin
                    line_cnt <= '0;
                end else begin
                    line_cnt <= line_cnt + NFA_ADDR_WIDTH'(1);
                    if (line_cnt == MAX_ADDR) begin
                        nfa_overflow <= 1'b1;
                    end
                end
            end
            if (proto_hit) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Query line buffer and word serialiser
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_line        <= '0;
            buf_last        <= 1'b0;
            slot            <= '0;
            m_query_tvalid  <= 1'b0;
            m_query_tdata   <= '0;
            m_query_tlast   <= 1'b0;
            query_words_out <= '0;
        end else begin
            if (q_hs) begin
                query_words_out <= query_words_out + 32'(1);
            end
            if (q_accept) begin
                buf_line       <= s_axis_tdata;
                buf_last       <= s_axis_tlast;
                slot           <= '0;
                m_query_tvalid <= 1'b1;
                m_query_tdata  <= s_axis_tdata[QUERY_WIDTH-1:0];
                m_query_tlast  <= s_axis_tlast && (LAST_SLOT == '0);
            end else if (q_hs) begin
                if (slot == LAST_SLOT) begin
                    slot           <= '0;
                    m_query_tvalid <= 1'b0;
                    m_query_tlast  <= 1'b0;
                end else begin
                    slot          <= slot_nxt;
                    m_query_tdata <= lane_nxt;
                    m_query_tlast <= buf_last && (slot_nxt == LAST_SLOT);
                end
            end
        end
    end

endmodule

// File: tb/tb_nfa_query_dispatcher.sv
// Scoreboard bench for nfa_query_dispatcher: expected NFA writes and query
// words are queued at stimulus time and checked as the DUT emits them.
module tb_nfa_query_dispatcher;

    localparam int unsigned DW    = 512;
    localparam int unsigned QW    = 64;
    localparam int unsigned AW    = 10;
    localparam int unsigned LANES = DW / QW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          loaded;
    } nfa_exp_t;

    typedef struct {
        logic [QW-1:0] data;
        logic          last;
    } q_exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_ttype;
    logic          nfa_wr_en;
    logic [AW-1:0] nfa_wr_addr;
    logic [DW-1:0] nfa_wr_data;
    logic          nfa_loaded;
    logic          m_query_tvalid;
    logic          m_query_tready;
    logic [QW-1:0] m_query_tdata;
    logic          m_query_tlast;
    logic          nfa_overflow;
    logic          proto_err;
    logic [31:0]   query_words_out;

    int n_cmp  = 0;
    int n_fail = 0;

    nfa_exp_t nfa_q[$];
    q_exp_t   qry_q[$];

    logic          prev_stall = 1'b0;
    logic [QW-1:0] prev_data  = '0;

    nfa_query_dispatcher #(
        .DATA_WIDTH(DW), .QUERY_WIDTH(QW), .NFA_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_ttype(s_axis_ttype),
        .nfa_wr_en(nfa_wr_en), .nfa_wr_addr(nfa_wr_addr),
        .nfa_wr_data(nfa_wr_data), .nfa_loaded(nfa_loaded),
        .m_query_tvalid(m_query_tvalid), .m_query_tready(m_query_tready),
        .m_query_tdata(m_query_tdata), .m_query_tlast(m_query_tlast),
        .nfa_overflow(nfa_overflow), .proto_err(proto_err),
        .query_words_out(query_words_out)
    );

    always #5 clk = ~clk;

    // Output monitor: pops the scoreboards on every write / query handshake
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (nfa_wr_en === 1'b1) begin
                n_cmp++;
                if (nfa_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL nfa_unexpected: write addr %0d with nothing expected", nfa_wr_addr);
                end else begin
                    nfa_exp_t e;
                    e = nfa_q.pop_front();
                    if (nfa_wr_addr !== e.addr || nfa_wr_data !== e.data || nfa_loaded !== e.loaded) begin
                        n_fail++;
                        $display("FAIL nfa_write: got addr %0d loaded %b data %h, expected addr %0d loaded %b data %h",
                                 nfa_wr_addr, nfa_loaded, nfa_wr_data, e.addr, e.loaded, e.data);
                    end
                end
            end else if (nfa_loaded !== 1'b0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL nfa_loaded_alone: got %b expected 0", nfa_loaded);
            end
            if (prev_stall && m_query_tvalid === 1'b1) begin
                n_cmp++;
                if (m_query_tdata !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_stable: got %h expected %h", m_query_tdata, prev_data);
                end
            end
            if (m_query_tvalid === 1'b1 && m_query_tready === 1'b1) begin
                n_cmp++;
                if (qry_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL query_unexpected: word %h with nothing expected", m_query_tdata);
                end else begin
                    q_exp_t e;
                    e = qry_q.pop_front();
                    if (m_query_tdata !== e.data || m_query_tlast !== e.last) begin
                        n_fail++;
                        $display("FAIL query_word: got %h last %b, expected %h last %b",
                                 m_query_tdata, m_query_tlast, e.data, e.last);
                    end
                end
            end
            prev_stall = (m_query_tvalid === 1'b1) && (m_query_tready !== 1'b1);
            prev_data  = m_query_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic push_nfa(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic loaded);
        nfa_exp_t e;
        e.addr = addr; e.data = data; e.loaded = loaded;
        nfa_q.push_back(e);
    endtask

    task automatic push_query(input logic [DW-1:0] data, input logic last);
        q_exp_t e;
        for (int k = 0; k < int'(LANES); k++) begin
            e.data = data[k*QW +: QW];
            e.last = last && (k == int'(LANES) - 1);
            qry_q.push_back(e);
        end
    endtask

    // Presents one beat and returns after it is accepted; waits = stalled cycles
    task automatic send_beat(input logic typ, input logic last, input logic [DW-1:0] data, output int waits);
        s_axis_tvalid = 1'b1;
        s_axis_ttype  = typ;
        s_axis_tlast  = last;
        s_axis_tdata  = data;
        waits = 0;
        @(negedge clk);
        while (s_axis_tready !== 1'b1 && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (s_axis_tready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_timeout: s_axis_tready got %b expected 1", s_axis_tready);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int budget = 0;
        while ((nfa_q.size() != 0 || qry_q.size() != 0) && budget < 400) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (nfa_q.size() != 0 || qry_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: pending nfa %0d query %0d expected 0 0", name, nfa_q.size(), qry_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_ttype = 1'b0;
        m_query_tready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({nfa_wr_en, nfa_loaded, m_query_tvalid, m_query_tlast, nfa_overflow, proto_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {nfa_wr_en, nfa_loaded, m_query_tvalid, m_query_tlast, nfa_overflow, proto_err});
        end
        n_cmp++;
        if (nfa_wr_addr !== '0 || nfa_wr_data !== '0 || m_query_tdata !== '0 || query_words_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_buses: got addr %0d wdata %h qdata %h count %0d expected all 0",
                     nfa_wr_addr, nfa_wr_data, m_query_tdata, query_words_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tready: got %b expected 1", s_axis_tready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_nfa_load();
        logic [DW-1:0] d;
        int w;
        for (int i = 0; i < 3; i++) begin
            d = rand_line();
            push_nfa(AW'(i), d, i == 2);
            send_beat(1'b0, i == 2, d, w);
            n_cmp++;
            if (w != 0) begin
                n_fail++;
                $display("FAIL nfa_tready: stalled %0d cycles expected 0", w);
            end
        end
        wait_drain("nfa_load");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b;
        int w0, w1, cnt;
        a = rand_line();
        b = rand_line();
        m_query_tready = 1'b1;
        push_query(a, 1'b0);
        push_query(b, 1'b1);
        fork
            begin
                send_beat(1'b1, 1'b0, a, w0);
                send_beat(1'b1, 1'b1, b, w1);
            end
            begin
                cnt = 0;
                @(negedge clk);
                while (m_query_tvalid !== 1'b1 && cnt < 20) begin
                    cnt++;
                    @(negedge clk);
                end
                for (int i = 0; i < 2 * int'(LANES); i++) begin
                    n_cmp++;
                    if (m_query_tvalid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_gap: word %0d tvalid got %b expected 1", i, m_query_tvalid);
                    end
                    if (i < int'(LANES)) begin
                        n_cmp++;
                        if (s_axis_tready !== (i == int'(LANES) - 1)) begin
                            n_fail++;
                            $display("FAIL b2b_tready: word %0d got %b expected %b",
                                     i, s_axis_tready, i == int'(LANES) - 1);
                        end
                    end
                    @(negedge clk);
                end
            end
        join
        wait_drain("b2b");
        n_cmp++;
        if (query_words_out !== 32'd16) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 16", query_words_out);
        end
        m_query_tready = 1'b0;
    endtask

    task automatic test_stall();
        logic [DW-1:0] a;
        logic [31:0] base;
        int w, hs, budget;
        a = rand_line();
        base = query_words_out;
        m_query_tready = 1'b0;
        push_query(a, 1'b1);
        send_beat(1'b1, 1'b1, a, w);
        hs = 0;
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk);
                    #1;
                    m_query_tready = ~m_query_tready;
                end
                m_query_tready = 1'b0;
            end
            begin
                budget = 0;
                while (hs < int'(LANES) && budget < 60) begin
                    @(negedge clk);
                    budget++;
                    if (m_query_tvalid === 1'b1) begin
                        n_cmp++;
                        if (s_axis_tready !== (hs == int'(LANES) - 1 && m_query_tready === 1'b1)) begin
                            n_fail++;
                            $display("FAIL stall_tready: after %0d words got %b", hs, s_axis_tready);
                        end
                        if (m_query_tready === 1'b1) hs++;
                    end
                end
            end
        join
        wait_drain("stall");
        n_cmp++;
        if (query_words_out - base !== 32'd8 || m_query_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d words tvalid %b expected 8 words tvalid 0",
                     query_words_out - base, m_query_tvalid);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] d;
        int w;
        do_reset();
        for (int i = 0; i < 1025; i++) begin
            if (i == 1023) begin
                n_cmp++;
                if (nfa_overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL overflow_early: got %b expected 0", nfa_overflow);
                end
            end
            d = rand_line();
            push_nfa(AW'(i % 1024), d, i == 1024);
            send_beat(1'b0, i == 1024, d, w);
        end
        wait_drain("overflow");
        n_cmp++;
        if (nfa_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got %b expected 1", nfa_overflow);
        end
        d = rand_line();
        push_nfa(AW'(0), d, 1'b1);
        send_beat(1'b0, 1'b1, d, w);
        wait_drain("single_line");
        n_cmp++;
        if (nfa_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b expected 1", nfa_overflow);
        end
    endtask

    task automatic test_proto_err();
        logic [DW-1:0] d;
        int w;
        do_reset();
        d = rand_line();
        push_nfa(AW'(0), d, 1'b0);
        send_beat(1'b0, 1'b0, d, w);
        send_beat(1'b1, 1'b1, rand_line(), w);
        for (int i = 1; i < 3; i++) begin
            d = rand_line();
            push_nfa(AW'(i), d, i == 2);
            send_beat(1'b0, i == 2, d, w);
        end
        wait_drain("proto");
        n_cmp++;
        if (proto_err !== 1'b1 || m_query_tvalid !== 1'b0 || query_words_out !== 32'd0) begin
            n_fail++;
            $display("FAIL proto_err: got err %b tvalid %b count %0d expected 1 0 0",
                     proto_err, m_query_tvalid, query_words_out);
        end
    endtask

    task automatic test_reset_mid_query();
        logic [DW-1:0] a, b;
        int w;
        a = rand_line();
        m_query_tready = 1'b0;
        push_query(a, 1'b1);
        send_beat(1'b1, 1'b1, a, w);
        m_query_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_query_tready = 1'b0;
        n_cmp++;
        if (query_words_out !== 32'd3) begin
            n_fail++;
            $display("FAIL mid_count: got %0d expected 3", query_words_out);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        qry_q.delete();
        n_cmp++;
        if ({m_query_tvalid, m_query_tlast, proto_err, nfa_wr_en} !== 4'b0 ||
            m_query_tdata !== '0 || query_words_out !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got tvalid %b tlast %b err %b wr %b data %h count %0d expected all 0",
                     m_query_tvalid, m_query_tlast, proto_err, nfa_wr_en, m_query_tdata, query_words_out);
        end
        rst_n = 1'b1;
        b = rand_line();
        push_query(b, 1'b1);
        m_query_tready = 1'b1;
        send_beat(1'b1, 1'b1, b, w);
        wait_drain("mid_restart");
        n_cmp++;
        if (query_words_out !== 32'd8) begin
            n_fail++;
            $display("FAIL mid_restart_count: got %0d expected 8", query_words_out);
        end
        m_query_tready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nfa_load();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_proto_err();
        test_reset_mid_query();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
